// File: rtl/filter_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
// Shared definitions for the write-back filter sequencer:
//   - filter mode encodings presented to the filter bank
//   - sequencer state enum
//   - pixel type and a small mode-decode helper
// -----------------------------------------------------------------------------
package filter_pkg;

  typedef logic [31:0] argb_t;
  typedef logic [2:0]  mode_t;

  // Filter bank mux selections. Only the horizontal blur needs history
  // priming; every other mode is a per-pixel operation.
  localparam mode_t MODE_PASS    = 3'b000;
  localparam mode_t MODE_GRAY    = 3'b001;
  localparam mode_t MODE_INVERT  = 3'b010;
  localparam mode_t MODE_THRESH  = 3'b011;
  localparam mode_t MODE_SEPIA   = 3'b100;
  localparam mode_t MODE_HBLUR   = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_t;

  // True for modes whose filter keeps a horizontal history that must be
  // refilled with the row's edge pixel before the row starts.
  function automatic logic needs_prime(input mode_t m);
    return (m == MODE_HBLUR);
  endfunction

endpackage

// File: rtl/filter_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// filter_seq_ctrl_if
// Bundles the three streams around the sequencer:
//   in_*   : upstream ARGB pixel stream (valid/ready)
//   wb_en, mode_wb, filt_data, filt_result : filter bank control/data
//   out_*  : registered, backpressured output stream toward the write path
// Modports:
//   master : the sequencer (consumes pixels, drives the filter bank and output)
//   slave  : the surroundings (pixel source, filter bank, write path)
// -----------------------------------------------------------------------------
interface filter_seq_ctrl_if;
  import filter_pkg::*;

  // Upstream read stream
  logic  in_valid;
  argb_t in_data;
  logic  in_ready;

  // Filter bank
  logic  wb_en;
  mode_t mode_wb;
  argb_t filt_data;
  argb_t filt_result;

  // Downstream write stream
  logic  out_valid;
  argb_t out_data;
  logic  out_ready;

  modport master (
    input  in_valid, in_data, filt_result, out_ready,
    output in_ready, wb_en, mode_wb, filt_data, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, filt_result, out_ready,
    input  in_ready, wb_en, mode_wb, filt_data, out_valid, out_data
  );

endinterface

// File: rtl/dim_counter.sv
// -----------------------------------------------------------------------------
// dim_counter
// Column/row position tracker for one frame.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   clear           : zero both counters (frame start)
//   advance         : one pixel consumed; col steps, wrapping into row
//   row_width       : pixels per row (latched copy, never 0 while advancing)
//   num_rows        : rows per frame (latched copy, never 0 while advancing)
//   last_col        : current pixel is the last of its row
//   last_pixel      : current pixel is the last of the frame
// -----------------------------------------------------------------------------
module dim_counter #(
  parameter int DIM_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [DIM_W-1:0] row_width,
  input  logic [DIM_W-1:0] num_rows,
  output logic             last_col,
  output logic             last_pixel
);

  logic [DIM_W-1:0] col;
  logic [DIM_W-1:0] row;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (last_col) begin
        col <= '0;
        row <= row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

  assign last_col   = (col == row_width - DIM_W'(1));
  assign last_pixel = last_col && (row == num_rows - DIM_W'(1));

endmodule

// File: rtl/filter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// filter_seq_ctrl
// Sequencer for the write-back filter stage. Pulls ARGB pixels from the
// upstream stream, drives the filter bank (enable/mode/data), primes the
// horizontal-blur history with the row's edge pixel before every blur row,
// and registers the filter result into a backpressured output stream.
//
// Parameters:
//   DIM_W       : width of the row/column dimension values
//   PRIME_BEATS : replicated edge beats issued before each blur row (>= 1)
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : frame start pulse, honoured only when idle
//   mode              : filter mode, latched at start
//   row_width         : pixels per row, latched at start
//   num_rows          : rows per frame, latched at start
//   bus (master)      : in_* / filter bank / out_* streams
//   busy              : sequencer is not idle
//   done              : one-cycle pulse when the frame has fully drained
// -----------------------------------------------------------------------------
module filter_seq_ctrl
  import filter_pkg::*;
#(
  parameter int DIM_W       = 10,
  parameter int PRIME_BEATS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  mode_t              mode,
  input  logic [DIM_W-1:0]   row_width,
  input  logic [DIM_W-1:0]   num_rows,
  filter_seq_ctrl_if.master  bus,
  output logic               busy,
  output logic               done
);

  localparam int PW = (PRIME_BEATS > 1) ? $clog2(PRIME_BEATS) : 1;
  localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_BEATS - 1);

  seq_state_t       state;
  mode_t            mode_q;
  logic [DIM_W-1:0] width_q;
  logic [DIM_W-1:0] rows_q;
  logic [PW-1:0]    prime_cnt;
  logic             out_valid_q;
  argb_t            out_data_q;
  logic             done_q;

  logic  slot_free;
  logic  advance;
  logic  prime_beat;
  logic  frame_clear;
  logic  last_col;
  logic  last_pixel;
  logic  in_ready_c;
  logic  wb_en_c;
  argb_t filt_data_c;

  // The output register can take a new pixel when it is empty or is being
  // emptied by the downstream in this same cycle.
  assign slot_free   = !out_valid_q || bus.out_ready;
  assign advance     = (state == ST_RUN) && bus.in_valid && slot_free;
  // Priming shows the row's first pixel to the filter without consuming it.
  assign prime_beat  = (state == ST_PRIME) && bus.in_valid;
  assign frame_clear = (state == ST_IDLE) && start;

  dim_counter #(
    .DIM_W (DIM_W)
  ) u_dim (
    .clk        (clk),
    .rst        (rst),
    .clear      (frame_clear),
    .advance    (advance),
    .row_width  (width_q),
    .num_rows   (rows_q),
    .last_col   (last_col),
    .last_pixel (last_pixel)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    in_ready_c  = 1'b0;
    wb_en_c     = 1'b0;
    filt_data_c = '0;
    if (advance) begin
      in_ready_c  = 1'b1;
      wb_en_c     = 1'b1;
      filt_data_c = bus.in_data;
    end else if (prime_beat) begin
      wb_en_c     = 1'b1;
      filt_data_c = bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      mode_q      <= MODE_PASS;
      width_q     <= '0;
      rows_q      <= '0;
      prime_cnt   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // A capture in the same cycle as a downstream accept keeps the slot
      // full with the new pixel.
      if (advance) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.filt_result;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q    <= mode;
            width_q   <= row_width;
            rows_q    <= num_rows;
            prime_cnt <= '0;
            if (row_width == '0 || num_rows == '0) begin
              state <= ST_DRAIN;
            end else if (needs_prime(mode)) begin
              state <= ST_PRIME;
            end else begin
              state <= ST_RUN;
            end
          end
        end

        ST_PRIME: begin
          if (bus.in_valid) begin
            if (prime_cnt == PRIME_LAST) begin
              prime_cnt <= '0;
              state     <= ST_RUN;
            end else begin
              prime_cnt <= prime_cnt + PW'(1);
            end
          end
        end

        ST_RUN: begin
          if (advance && last_col) begin
            if (last_pixel) begin
              state <= ST_DRAIN;
            end else if (needs_prime(mode_q)) begin
              state <= ST_PRIME;
            end
          end
        end

        ST_DRAIN: begin
          // Frame is complete once the final pixel has left the output slot.
          if (slot_free) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.wb_en     = wb_en_c;
  assign bus.filt_data = filt_data_c;
  assign bus.mode_wb   = mode_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state != ST_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_filter_seq_ctrl
// Scoreboard bench for filter_seq_ctrl. The bench plays the pixel source, a
// behavioural filter bank (4-tap horizontal box blur for MODE_HBLUR, an XOR
// tag for the other modes) and the write path. Expected outputs come from a
// frame-level model: blur output i of a row averages pixels i..i-3 with the
// index clamped to the row's first pixel.
// -----------------------------------------------------------------------------
module tb_filter_seq_ctrl;
  import filter_pkg::*;

  localparam int DIM_W = 10;
  localparam int PB    = 3;

  logic             clk;
  logic             rst;
  logic             start;
  mode_t            mode;
  logic [DIM_W-1:0] row_width;
  logic [DIM_W-1:0] num_rows;
  logic             busy;
  logic             done;

  filter_seq_ctrl_if bus ();

  filter_seq_ctrl #(
    .DIM_W       (DIM_W),
    .PRIME_BEATS (PB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .row_width (row_width),
    .num_rows  (num_rows),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  argb_t pix_q [$];
  argb_t exp_q [$];
  argb_t pix_src [$];
  argb_t given_exp [$];
  bit    gaps;
  bit    stall_force;
  mode_t frame_mode;
  int    n_out, done_cnt, prime_cnt, wb_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic argb_t avg4(input argb_t a, input argb_t b, input argb_t c, input argb_t d);
    argb_t r;
    logic [9:0] s;
    for (int i = 0; i < 4; i++) begin
      s = 10'(a[i*8 +: 8]) + 10'(b[i*8 +: 8]) + 10'(c[i*8 +: 8]) + 10'(d[i*8 +: 8]);
      r[i*8 +: 8] = s[9:2];
    end
    return r;
  endfunction

  function automatic argb_t tag(input mode_t m, input argb_t p);
    return p ^ {4{m, 5'h15}};
  endfunction

  // Behavioural filter bank: 3-deep history shifted on wb_en.
  argb_t hist [3];
  always @(posedge clk) begin
    if (bus.wb_en) begin
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= bus.filt_data;
    end
  end

  always_comb begin
    if (bus.mode_wb == MODE_HBLUR) bus.filt_result = avg4(bus.filt_data, hist[0], hist[1], hist[2]);
    else                           bus.filt_result = tag(bus.mode_wb, bus.filt_data);
  end

  // Pixel source: always presents the head of pix_q; pops after a handshake.
  initial begin
    bit hs;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    forever begin
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (hs && pix_q.size() > 0) void'(pix_q.pop_front());
      if (pix_q.size() > 0) begin
        bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.in_data  = pix_q[0];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
      end
    end
  end

  // Write path.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = (gaps ? ($urandom_range(0, 3) != 0) : 1'b1) && !stall_force;
    end
  end

  // Monitor / scoreboard.
  bit    acc_pending, held_pending, done_prev;
  argb_t acc_result, held_data;
  always @(negedge clk) begin
    if (rst) begin
      acc_pending  = 1'b0;
      held_pending = 1'b0;
      done_prev    = 1'b0;
    end else begin
      if (acc_pending) begin
        check("latency_valid", 32'(bus.out_valid), 32'd1);
        check("latency_data", bus.out_data, acc_result);
      end
      if (held_pending) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", bus.out_data, held_data);
      end
      if (bus.out_valid && !bus.out_ready) check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      if (!busy) check("idle_wb_en", 32'(bus.wb_en), 32'd0);
      else       check("mode_wb", 32'(bus.mode_wb), 32'(frame_mode));
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_extra: got %h with nothing expected at %0t", bus.out_data, $time);
        end else begin
          check("out_data", bus.out_data, exp_q.pop_front());
        end
      end
      if (bus.wb_en) wb_cnt++;
      if (bus.wb_en && !bus.in_ready) prime_cnt++;
      if (done) begin
        done_cnt++;
        if (done_prev) begin
          total++;
          bad++;
          $display("FAIL done_width: got 2-cycle pulse expected 1 at %0t", $time);
        end
      end
      done_prev    = done;
      acc_pending  = bus.in_valid && bus.in_ready;
      acc_result   = bus.filt_result;
      held_pending = bus.out_valid && !bus.out_ready;
      held_data    = bus.out_data;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    pix_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic run_frame(input mode_t m, input int w, input int r,
                           input bit use_given, input bit stall, input bit stray);
    int n, k, limit, exp_cycles, d0, o0, p0, w0;
    argb_t p;
    n = w * r;
    if (!use_given) begin
      pix_src.delete();
      for (int i = 0; i < n; i++) pix_src.push_back($urandom);
    end
    for (int rr = 0; rr < r; rr++) begin
      for (int cc = 0; cc < w; cc++) begin
        p = pix_src[rr*w + cc];
        if (use_given) exp_q.push_back(given_exp[rr*w + cc]);
        else if (m == MODE_HBLUR)
          exp_q.push_back(avg4(p, pix_src[rr*w + ((cc > 0) ? cc-1 : 0)],
                                  pix_src[rr*w + ((cc > 1) ? cc-2 : 0)],
                                  pix_src[rr*w + ((cc > 2) ? cc-3 : 0)]));
        else exp_q.push_back(tag(m, p));
      end
    end
    foreach (pix_src[i]) pix_q.push_back(pix_src[i]);
    frame_mode = m;
    d0 = done_cnt; o0 = n_out; p0 = prime_cnt; w0 = wb_cnt;
    exp_cycles = n + ((m == MODE_HBLUR && n > 0) ? r * PB : 0) + 2 + (stall ? 5 : 0);

    @(posedge clk);
    #1;
    start = 1'b1; mode = m; row_width = DIM_W'(w); num_rows = DIM_W'(r);
    @(posedge clk);
    #1;
    start = 1'b0;
    fork
      begin
        if (stall) begin
          repeat (3) @(posedge clk);
          stall_force = 1'b1;
          repeat (5) @(posedge clk);
          stall_force = 1'b0;
        end
      end
      begin
        if (stray) begin
          repeat (2) @(posedge clk);
          #1;
          start = 1'b1; mode = MODE_INVERT; row_width = DIM_W'(1); num_rows = DIM_W'(1);
          @(posedge clk);
          #1;
          start = 1'b0;
        end
      end
    join_none

    limit = 20 * (n + 10) + 10 * r;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < limit);

    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no done within %0d cycles (mode %0d %0dx%0d)", limit, m, w, r);
      do_reset();
    end else begin
      if (!gaps) check("frame_cycles", 32'(k), 32'(exp_cycles));
      repeat (3) @(negedge clk);
      check("done_count", 32'(done_cnt - d0), 32'd1);
      check("out_count", 32'(n_out - o0), 32'(n));
      check("exp_left", 32'(exp_q.size()), 32'd0);
      check("pix_left", 32'(pix_q.size()), 32'd0);
      check("prime_beats", 32'(prime_cnt - p0), 32'((m == MODE_HBLUR && n > 0) ? r * PB : 0));
      if (n == 0) check("zero_wb_en", 32'(wb_cnt - w0), 32'd0);
      check("busy_after", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int d0;
    rst = 1'b0; start = 1'b0; mode = '0; row_width = '0; num_rows = '0;
    gaps = 1'b0; stall_force = 1'b0; frame_mode = '0;
    n_out = 0; done_cnt = 0; prime_cnt = 0; wb_cnt = 0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_wb_en", 32'(bus.wb_en), 32'd0);
    check("rst_mode_wb", 32'(bus.mode_wb), 32'd0);
    check("rst_filt_data", bus.filt_data, 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Blur, one 4-pixel row with known values.
    pix_src = '{32'hFF101010, 32'hFF202020, 32'hFF303030, 32'hFF404040};
    given_exp = '{32'hFF101010, 32'hFF141414, 32'hFF1C1C1C, 32'hFF282828};
    run_frame(MODE_HBLUR, 4, 1, 1'b1, 1'b0, 1'b0);

    // Blur, 2 rows x 2 pixels: each row re-primed with its own edge pixel.
    run_frame(MODE_HBLUR, 2, 2, 1'b0, 1'b0, 1'b0);
    // Per-pixel mode, 3 x 2: no priming, 1 pixel/cycle.
    run_frame(MODE_PASS, 3, 2, 1'b0, 1'b0, 1'b0);
    // Downstream stall of 5 cycles mid-row.
    run_frame(MODE_GRAY, 4, 2, 1'b0, 1'b1, 1'b0);
    // Zero-dimension frames.
    run_frame(MODE_HBLUR, 0, 2, 1'b0, 1'b0, 1'b0);
    run_frame(MODE_PASS, 3, 0, 1'b0, 1'b0, 1'b0);
    // Stray start while busy must be ignored.
    run_frame(MODE_HBLUR, 5, 2, 1'b0, 1'b0, 1'b1);

    // Reset mid-row aborts immediately without a done pulse.
    pix_src.delete();
    for (int i = 0; i < 12; i++) pix_src.push_back($urandom | 32'h1);
    foreach (pix_src[i]) pix_q.push_back(pix_src[i]);
    for (int i = 0; i < 12; i++) exp_q.push_back(tag(MODE_THRESH, pix_src[i]));
    frame_mode = MODE_THRESH;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b1; mode = MODE_THRESH; row_width = DIM_W'(6); num_rows = DIM_W'(2);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd0);
    check("abort_wb_en", 32'(bus.wb_en), 32'd0);
    check("abort_mode_wb", 32'(bus.mode_wb), 32'd0);
    check("abort_filt_data", bus.filt_data, 32'd0);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_out_data", bus.out_data, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    pix_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_frame(MODE_SEPIA, 4, 2, 1'b0, 1'b0, 1'b0);

    // Randomized frames with input gaps and random backpressure.
    gaps = 1'b1;
    for (int it = 0; it < 8; it++) begin
      mode_t m;
      m = ($urandom_range(0, 1) != 0) ? MODE_HBLUR : mode_t'($urandom_range(0, 4));
      run_frame(m, $urandom_range(1, 6), $urandom_range(1, 3), 1'b0, 1'b0, 1'b0);
    end
    gaps = 1'b0;
    run_frame(MODE_HBLUR, 3, 3, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/filter_seq_ctrl.md
# filter_seq_ctrl

Sequencer for the write-back filter stage. Pulls ARGB pixels from the upstream read stream and drives the filter bank's enable, mode and data inputs. Primes the horizontal-blur history at the start of every row with replicated edge pixels. Registers the selected filter result into a backpressured output stream toward the write path.

## Interface

Parameters:
- `DIM_W`, default 10: width of row/column dimension counters.
- `PRIME_BEATS`, default 3: replicated edge beats issued before each blur row.

Ports:
- `clk`, in, 1: system clock; all logic on rising edge.
- `rst`, in, 1: asynchronous active-high reset.
- `start`, in, 1: one-cycle pulse that begins a frame; honoured only in IDLE.
- `mode`, in, 3: filter mode; latched at `start`.
- `row_width`, in, DIM_W: pixels per row; latched at `start`.
- `num_rows`, in, DIM_W: rows per frame; latched at `start`.
- `in_valid`, in, 1: upstream pixel valid.
- `in_data`, in, 32: upstream ARGB pixel.
- `in_ready`, out, 1: pixel consumed this cycle when high with `in_valid`.
- `wb_en`, out, 1: filter bank enable (history shift).
- `mode_wb`, out, 3: mode presented to the filter bank.
- `filt_data`, out, 32: pixel presented to the filter bank.
- `filt_result`, in, 32: combinational result from the filter bank mux.
- `out_valid`, out, 1: output register holds a pixel.
- `out_data`, out, 32: filtered ARGB pixel.
- `out_ready`, in, 1: downstream accepts when high with `out_valid`.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse at frame completion.

## Operation

States:
- IDLE
- PRIME
- RUN
- DRAIN

Transitions and behaviour:
- IDLE + `start`: latch `mode`, `row_width` and `num_rows`; clear `col` and `row`.
  - If `row_width == 0` or `num_rows == 0`, go to DRAIN.
  - Else, if mode is `MODE_HBLUR` (3'b101), go to PRIME.
  - Else, go to RUN.
- PRIME: `in_ready = 0`. While `in_valid` is high, assert `wb_en` and present `filt_data = in_data` (the row's first pixel, not consumed). Count beats. After `PRIME_BEATS` beats, go to RUN. A PRIME cycle with `in_valid` low neither counts a beat nor asserts `wb_en`. No output is produced in PRIME.
- RUN: slot_free = `!out_valid || out_ready`. Advance = `in_valid && slot_free`. On advance:
  - `in_ready = wb_en = 1`, `filt_data = in_data`.
  - Capture `filt_result` into `out_data` and set `out_valid`.
  - Increment `col`.
- End of row, on advance with `col == row_width-1`:
  - Clear `col` and increment `row`.
  - If this was the last row, go to DRAIN; else go to PRIME (blur mode) or stay in RUN.
- DRAIN: wait until `out_valid` is low or is being accepted this cycle. Then pulse `done` and go to IDLE.
- `out_valid` clears on `out_ready` unless a new capture occurs in the same cycle (capture wins).
- `mode_wb` always equals the latched mode; `wb_en` is low outside PRIME and RUN.
- `start` outside IDLE is ignored.
- Non-blur modes never enter PRIME.

## Timing

- Reset values: state IDLE, `in_ready 0`, `wb_en 0`, `mode_wb 0`, `filt_data 0`, `out_valid 0`, `out_data 0`, `busy 0`, `done 0`, all counters 0.
- Reset mid-frame aborts immediately; no `done` pulse.
- `in_ready`, `wb_en` and `filt_data` are combinational from state, `in_valid` and slot_free. `out_*` are registered.
- Latency from input accept to `out_valid`: 1 cycle. Throughput is 1 pixel/cycle in RUN with `out_ready` held high.
- Blur row overhead: `PRIME_BEATS` cycles, given `in_valid` high.
- `done` is asserted the cycle after the last output handshake, or 1 cycle after `start` for a zero-dimension frame.

## Structure

- `filter_pkg`: `MODE_HBLUR` and the other mode constants, plus the state enum.
- Sub-module `dim_counter`: `col`/`row` counters with wrap and last-pixel flag; instantiated once.
- Everything else lives in one FSM module.

## Test plan

- Blur, width 4, 1 row, pixels 0xFF101010/0xFF202020/0xFF303030/0xFF404040, with the bench driving the horizontal blur filter:
  - Outputs must be 0xFF101010, 0xFF141414, 0xFF1C1C1C, 0xFF282828.
  - Exactly 3 prime beats; then `done`.
- Blur, 2 rows × 2 pixels: second row is re-primed with its own first pixel; the first output of row 2 equals that pixel; 4 outputs, 1 `done`.
- Mode 3'b000, width 3 × 2 rows: no PRIME cycles; 6 outputs, each equal to `filt_result`, 1-cycle latency.
- `out_ready` low for 5 cycles mid-row:
  - `in_ready` drops; `out_data` holds; no pixel is lost or duplicated.
  - Resumes at 1 pixel/cycle.
- `row_width = 0`: `done` 1 cycle after `start`; no `wb_en`, no output.
- `rst` asserted mid-row and `start` pulsed while busy:
  - All outputs return to reset values immediately.
  - Stray `start` ignored; a fresh frame afterwards produces correct values.
